// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter_if
// Purpose  : Requester, shared-ALU and response signals of alu_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  req0_valid;
    logic [DATA_WIDTH-1:0] req0_A;
    logic [DATA_WIDTH-1:0] req0_B;
    logic [2:0]            req0_op;
    logic                  req0_ready;

    logic                  req1_valid;
    logic [DATA_WIDTH-1:0] req1_A;
    logic [DATA_WIDTH-1:0] req1_B;
    logic [2:0]            req1_op;
    logic                  req1_ready;

    logic [DATA_WIDTH-1:0] alu_A;
    logic [DATA_WIDTH-1:0] alu_B;
    logic [2:0]            alu_op;
    logic [DATA_WIDTH-1:0] alu_Result;
    logic                  alu_Overflow;
    logic                  alu_CarryOut;
    logic                  alu_Zero;

    logic                  resp_valid;
    logic                  resp_id;
    logic [DATA_WIDTH-1:0] resp_Result;
    logic                  resp_Overflow;
    logic                  resp_CarryOut;
    logic                  resp_Zero;
    logic                  resp_ready;

    // Environment side: requesters, the ALU itself and the response consumer.
    modport master (
        output req0_valid, req0_A, req0_B, req0_op,
        input  req0_ready,
        output req1_valid, req1_A, req1_B, req1_op,
        input  req1_ready,
        input  alu_A, alu_B, alu_op,
        output alu_Result, alu_Overflow, alu_CarryOut, alu_Zero,
        input  resp_valid, resp_id, resp_Result, resp_Overflow, resp_CarryOut, resp_Zero,
        output resp_ready
    );

    modport slave (
        input  req0_valid, req0_A, req0_B, req0_op,
        output req0_ready,
        input  req1_valid, req1_A, req1_B, req1_op,
        output req1_ready,
        output alu_A, alu_B, alu_op,
        input  alu_Result, alu_Overflow, alu_CarryOut, alu_Zero,
        output resp_valid, resp_id, resp_Result, resp_Overflow, resp_CarryOut, resp_Zero,
        input  resp_ready
    );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Round-robin sharing of one combinational ALU between two requesters.
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int DATA_WIDTH = 32
) (
    input  wire logic   clk,
    input  wire logic   resetn,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_rr;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic [2:0]            r_op;
    logic                  r_id;
    logic                  r_resp_valid;
    logic                  r_resp_id;
    logic [DATA_WIDTH-1:0] r_resp_result;
    logic                  r_resp_overflow;
    logic                  r_resp_carry;
    logic                  r_resp_zero;

    logic                  w_grant;
    logic                  w_grant_id;

    // Ready is combinational so the grant and operand capture share one cycle;
    // gating with resetn keeps both readies low while reset is held.
    always_comb begin
        w_grant    = resetn && (r_state == S_IDLE) && (bus.req0_valid || bus.req1_valid);
        w_grant_id = (bus.req0_valid && bus.req1_valid) ? r_rr : bus.req1_valid;
    end

    assign bus.req0_ready = w_grant && !w_grant_id;
    assign bus.req1_ready = w_grant &&  w_grant_id;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state         <= S_IDLE;
            r_rr            <= 1'b0;
            r_a             <= '0;
            r_b             <= '0;
            r_op            <= 3'b000;
            r_id            <= 1'b0;
            r_resp_valid    <= 1'b0;
            r_resp_id       <= 1'b0;
            r_resp_result   <= '0;
            r_resp_overflow <= 1'b0;
            r_resp_carry    <= 1'b0;
            r_resp_zero     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_a     <= w_grant_id ? bus.req1_A  : bus.req0_A;
                        r_b     <= w_grant_id ? bus.req1_B  : bus.req0_B;
                        r_op    <= w_grant_id ? bus.req1_op : bus.req0_op;
                        r_id    <= w_grant_id;
                        r_rr    <= ~w_grant_id;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_resp_result   <= bus.alu_Result;
                    r_resp_overflow <= bus.alu_Overflow;
                    r_resp_carry    <= bus.alu_CarryOut;
                    r_resp_zero     <= bus.alu_Zero;
                    r_resp_id       <= r_id;
                    r_resp_valid    <= 1'b1;
                    r_state         <= S_RESP;
                end
                S_RESP: begin
                    if (bus.resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_resp_valid <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.alu_A         = r_a;
    assign bus.alu_B         = r_b;
    assign bus.alu_op        = r_op;
    assign bus.resp_valid    = r_resp_valid;
    assign bus.resp_id       = r_resp_id;
    assign bus.resp_Result   = r_resp_result;
    assign bus.resp_Overflow = r_resp_overflow;
    assign bus.resp_CarryOut = r_resp_carry;
    assign bus.resp_Zero     = r_resp_zero;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Purpose  : Directed self-checking bench for alu_arbiter with a model ALU.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;
    logic clk;
    logic resetn;
    int   n_checks;
    int   n_fail;

    alu_arbiter_if #(.DATA_WIDTH(32)) bus ();

    alu_arbiter #(.DATA_WIDTH(32)) u_dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model ALU; the unused code 3'b101 returns A^B so forwarding is visible.
    logic [32:0] w_sum;
    always_comb begin
        w_sum            = {1'b0, bus.alu_A} + {1'b0, bus.alu_B};
        bus.alu_CarryOut = 1'b0;
        bus.alu_Overflow = 1'b0;
        case (bus.alu_op)
            3'b000: bus.alu_Result = bus.alu_A & bus.alu_B;
            3'b001: bus.alu_Result = bus.alu_A | bus.alu_B;
            3'b010: begin
                bus.alu_Result   = w_sum[31:0];
                bus.alu_CarryOut = w_sum[32];
                bus.alu_Overflow = (bus.alu_A[31] == bus.alu_B[31]) && (w_sum[31] != bus.alu_A[31]);
            end
            3'b110: begin
                bus.alu_Result   = bus.alu_A - bus.alu_B;
                bus.alu_Overflow = (bus.alu_A[31] != bus.alu_B[31]) && (bus.alu_Result[31] != bus.alu_A[31]);
            end
            3'b111: bus.alu_Result = {31'd0, $signed(bus.alu_A) < $signed(bus.alu_B)};
            default: bus.alu_Result = bus.alu_A ^ bus.alu_B;
        endcase
        bus.alu_Zero = (bus.alu_Result == 32'd0);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_id;
        n_checks = 0;
        n_fail   = 0;
        resetn   = 1'b0;
        bus.req0_valid = 1'b0; bus.req0_A = '0; bus.req0_B = '0; bus.req0_op = 3'b000;
        bus.req1_valid = 1'b0; bus.req1_A = '0; bus.req1_B = '0; bus.req1_op = 3'b000;
        bus.resp_ready = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state, with a request already waiting
        bus.req0_valid = 1'b1; bus.req0_A = 32'd7; bus.req0_B = 32'd5; bus.req0_op = 3'b010;
        #1;
        check("rst_ready0", bus.req0_ready, 0);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_alu_A", bus.alu_A, 0);
        check("rst_alu_op", bus.alu_op, 0);
        check("rst_result", bus.resp_Result, 0);
        check("rst_id_flags", {bus.resp_id, bus.resp_Overflow, bus.resp_CarryOut, bus.resp_Zero}, 0);

        // Single request: grant in the first cycle out of reset
        @(negedge clk); resetn = 1'b1; #1;
        check("t1_ready0", bus.req0_ready, 1);
        check("t1_ready1", bus.req1_ready, 0);
        @(negedge clk); #1;
        check("t1_exec_ready0", bus.req0_ready, 0);
        check("t1_exec_rv", bus.resp_valid, 0);
        check("t1_alu_A", bus.alu_A, 7);
        bus.req0_valid = 1'b0;
        @(negedge clk); #1;
        check("t1_rv", bus.resp_valid, 1);
        check("t1_id", bus.resp_id, 0);
        check("t1_result", bus.resp_Result, 12);
        check("t1_zero", bus.resp_Zero, 0);
        @(negedge clk); #1;
        check("t1_rv_drop", bus.resp_valid, 0);

        // Operand change after accept
        bus.req1_valid = 1'b1; bus.req1_A = 32'd10; bus.req1_B = 32'd4; bus.req1_op = 3'b010;
        #1;
        check("t2_ready1", bus.req1_ready, 1);
        check("t2_ready0", bus.req0_ready, 0);
        @(negedge clk);
        bus.req1_A = 32'd100; bus.req1_valid = 1'b0; #1;
        check("t2_alu_A", bus.alu_A, 10);
        @(negedge clk); #1;
        check("t2_result", bus.resp_Result, 14);
        check("t2_id", bus.resp_id, 1);
        @(negedge clk);

        // Backpressure with a pending request on the other port
        bus.resp_ready = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_A = 32'hFFFF_FFFF; bus.req0_B = 32'd1; bus.req0_op = 3'b010;
        #1;
        check("t3_ready0", bus.req0_ready, 1);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b1; bus.req1_A = 32'd5; bus.req1_B = 32'd3; bus.req1_op = 3'b101;
        #1;
        check("t3_exec_ready1", bus.req1_ready, 0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t3_hold_rv", bus.resp_valid, 1);
            check("t3_hold_result", bus.resp_Result, 0);
            check("t3_hold_flags", {bus.resp_Overflow, bus.resp_CarryOut, bus.resp_Zero}, 3'b011);
            check("t3_hold_ready1", bus.req1_ready, 0);
            @(negedge clk);
        end
        bus.resp_ready = 1'b1; #1;
        check("t3_rv_before_hs", bus.resp_valid, 1);
        @(negedge clk); #1;
        check("t3_idle_rv", bus.resp_valid, 0);
        check("t3_pending_ready1", bus.req1_ready, 1);
        @(negedge clk);
        bus.req1_valid = 1'b0; #1;
        check("t3_alu_op_fwd", bus.alu_op, 3'b101);
        @(negedge clk); #1;
        check("t3_op5_result", bus.resp_Result, 6);
        check("t3_op5_id", bus.resp_id, 1);
        @(negedge clk);

        // Reset during EXEC, after a req0 grant moved rr to requester 1
        bus.req0_valid = 1'b1; bus.req0_A = 32'd1; bus.req0_B = 32'd1; bus.req0_op = 3'b010;
        #1;
        check("t4_ready0", bus.req0_ready, 1);
        @(negedge clk);
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b1; resetn = 1'b0; #1;
        check("t4_rst_rv", bus.resp_valid, 0);
        check("t4_rst_alu_A", bus.alu_A, 0);
        check("t4_rst_alu_op", bus.alu_op, 0);
        check("t4_rst_ready1", bus.req1_ready, 0);
        @(negedge clk); #1;
        check("t4_rst_rv2", bus.resp_valid, 0);
        check("t4_rst_result", bus.resp_Result, 0);

        // Contention after reset: req0 first, then alternating
        @(negedge clk);
        bus.req0_valid = 1'b1; bus.req0_A = 32'd3; bus.req0_B = 32'd3; bus.req0_op = 3'b110;
        bus.req1_valid = 1'b1; bus.req1_A = 32'h7FFF_FFFF; bus.req1_B = 32'd1; bus.req1_op = 3'b010;
        resetn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_id = k[0];
            #1;
            check("t5_ready0", bus.req0_ready, !exp_id);
            check("t5_ready1", bus.req1_ready, exp_id);
            @(negedge clk); #1;
            check("t5_exec_rv", bus.resp_valid, 0);
            @(negedge clk); #1;
            check("t5_id", bus.resp_id, exp_id);
            check("t5_result", bus.resp_Result, exp_id ? 32'h8000_0000 : 32'd0);
            check("t5_zero", bus.resp_Zero, !exp_id);
            check("t5_overflow", bus.resp_Overflow, exp_id);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
